// File: rtl/lcd_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_cmd_pkg
//  Purpose  : Shared definitions for the SPI LCD command decoder: opcodes,
//             argument-table ROM entry layout and lookup function, COLMOD
//             codes, MADCTL bit indices and the decoder state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package lcd_cmd_pkg;

   // Opcodes (ST7735 / ILI9341 command set subset)
   localparam logic [7:0] OP_NOP     = 8'h00;
   localparam logic [7:0] OP_SWRESET = 8'h01;
   localparam logic [7:0] OP_SLPOUT  = 8'h11;
   localparam logic [7:0] OP_INVOFF  = 8'h20;
   localparam logic [7:0] OP_INVON   = 8'h21;
   localparam logic [7:0] OP_DISPOFF = 8'h28;
   localparam logic [7:0] OP_DISPON  = 8'h29;
   localparam logic [7:0] OP_CASET   = 8'h2A;
   localparam logic [7:0] OP_RASET   = 8'h2B;
   localparam logic [7:0] OP_RAMWR   = 8'h2C;
   localparam logic [7:0] OP_MADCTL  = 8'h36;
   localparam logic [7:0] OP_COLMOD  = 8'h3A;
   localparam logic [7:0] OP_FRMCTR1 = 8'hB1;
   localparam logic [7:0] OP_PWCTR1  = 8'hC0;
   localparam logic [7:0] OP_GMCTRP1 = 8'hE0;

   // Argument-table ROM entry: 'exists' = command takes fixed arguments,
   // 'varlen' = open-ended data stream, 'len_m1' = argument count minus one.
   localparam int ROM_LEN_W = 4;

   typedef struct packed {
      logic                 exists;
      logic                 varlen;
      logic [ROM_LEN_W-1:0] len_m1;
   } rom_entry_t;

   // COLMOD pixel formats
   localparam logic [2:0] COLMOD_RGB565 = 3'b101;
   localparam logic [2:0] COLMOD_RGB666 = 3'b110;
   localparam logic [2:0] COLMOD_RST    = COLMOD_RGB666;

   // MADCTL bit indices
   localparam int MADCTL_MV = 5;
   localparam int MADCTL_MX = 6;
   localparam int MADCTL_MY = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARGS  = 2'd1,
      ST_PIXEL = 2'd2
   } state_t;

   // Argument-count lookup. Opcodes not listed take no arguments. The panel
   // tuning commands are listed only so their arguments are skipped cleanly.
   function automatic rom_entry_t arg_rom(input logic [7:0] op);
      rom_entry_t e;
      e = '{exists: 1'b0, varlen: 1'b0, len_m1: '0};
      case (op)
         OP_CASET,
         OP_RASET:   e = '{exists: 1'b1, varlen: 1'b0, len_m1: 4'd3};
         OP_MADCTL,
         OP_COLMOD:  e = '{exists: 1'b1, varlen: 1'b0, len_m1: 4'd0};
         OP_RAMWR:   e = '{exists: 1'b0, varlen: 1'b1, len_m1: 4'd0};
         OP_FRMCTR1,
         OP_PWCTR1:  e = '{exists: 1'b1, varlen: 1'b0, len_m1: 4'd2};
         OP_GMCTRP1: e = '{exists: 1'b1, varlen: 1'b0, len_m1: 4'd15};
         default:    e = '{exists: 1'b0, varlen: 1'b0, len_m1: '0};
      endcase
      return e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_cmd_decoder_if
//  Purpose  : Byte stream from the SPI slave and addressed pixel writes to
//             the frame-buffer writer, named from the decoder's viewpoint.
//  Signals  : i_spi_data/i_spi_rxdone/i_spi_csreleased/i_spi_dc  (to decoder)
//             o_pix_valid/o_pix_data/o_pix_x/o_pix_y            (from decoder)
//  Modports : slave  - the decoder
//             master - the SPI front end / frame-buffer side
//  Revision : 1.0 - initial release
// ============================================================================
interface lcd_cmd_decoder_if #(
   parameter int COORD_W = 9
) ();
   logic [7:0]         i_spi_data;
   logic               i_spi_rxdone;
   logic               i_spi_csreleased;
   logic               i_spi_dc;
   logic               o_pix_valid;
   logic [17:0]        o_pix_data;
   logic [COORD_W-1:0] o_pix_x;
   logic [COORD_W-1:0] o_pix_y;

   modport slave (
      input  i_spi_data, i_spi_rxdone, i_spi_csreleased, i_spi_dc,
      output o_pix_valid, o_pix_data, o_pix_x, o_pix_y
   );

   modport master (
      output i_spi_data, i_spi_rxdone, i_spi_csreleased, i_spi_dc,
      input  o_pix_valid, o_pix_data, o_pix_x, o_pix_y
   );
endinterface
`default_nettype wire

// File: rtl/lcd_win_cursor.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_win_cursor
//  Purpose  : Column/row window registers (XS/XE/YS/YE) and the x/y write
//             cursor. Window pairs are ordered and the end clamped to the
//             panel size on write; the cursor raster-scans the window and
//             wraps to (XS,YS) at the end of the window.
//  Ports    : i_clk, i_rst_n      clock, async active-low reset
//             i_win_rst           return window/cursor to reset values
//             i_set_col/i_set_row commit i_start/i_end to the column/row pair
//             i_load              cursor <= (XS,YS)
//             i_advance           step cursor after a pixel
//             o_x, o_y            current cursor
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_win_cursor #(
   parameter int COORD_W = 9,
   parameter int H_RES   = 320,
   parameter int V_RES   = 240
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_win_rst,
   input  logic               i_set_col,
   input  logic               i_set_row,
   input  logic [COORD_W-1:0] i_start,
   input  logic [COORD_W-1:0] i_end,
   input  logic               i_load,
   input  logic               i_advance,
   output logic [COORD_W-1:0] o_x,
   output logic [COORD_W-1:0] o_y
);
   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

   logic [COORD_W-1:0] xs_q, xe_q, ys_q, ye_q, x_q, y_q;
   logic [COORD_W-1:0] w_lo, w_hi, w_hi_x, w_hi_y;

   // A reversed pair is stored swapped; the end is then clamped to the panel.
   assign w_lo   = (i_start > i_end) ? i_end   : i_start;
   assign w_hi   = (i_start > i_end) ? i_start : i_end;
   assign w_hi_x = (w_hi > X_MAX) ? X_MAX : w_hi;
   assign w_hi_y = (w_hi > Y_MAX) ? Y_MAX : w_hi;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         xs_q <= '0;
         xe_q <= X_MAX;
         ys_q <= '0;
         ye_q <= Y_MAX;
         x_q  <= '0;
         y_q  <= '0;
      end else if (i_win_rst) begin
         xs_q <= '0;
         xe_q <= X_MAX;
         ys_q <= '0;
         ye_q <= Y_MAX;
         x_q  <= '0;
         y_q  <= '0;
      end else begin
         if (i_set_col) begin
            xs_q <= w_lo;
            xe_q <= w_hi_x;
         end
         if (i_set_row) begin
            ys_q <= w_lo;
            ye_q <= w_hi_y;
         end
         if (i_load) begin
            x_q <= xs_q;
            y_q <= ys_q;
         end else if (i_advance) begin
            if (x_q == xe_q) begin
               x_q <= xs_q;
               y_q <= (y_q == ye_q) ? ys_q : y_q + 1'b1;
            end else begin
               x_q <= x_q + 1'b1;
            end
         end
      end
   end

   assign o_x = x_q;
   assign o_y = y_q;

endmodule
`default_nettype wire

// File: rtl/lcd_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_cmd_decoder
//  Purpose  : Decodes the ST7735/ILI-style SPI command stream, holds the
//             display control registers and emits addressed pixel writes.
//  Ports    : i_clk, i_rst_n   clock, async active-low reset
//             bus (slave)      SPI byte stream in, pixel writes out
//             o_sram_clr_req   one-cycle pulse on SWRESET
//             o_disp_on        display enable
//             o_inv_on         colour inversion
//  Params   : COORD_W, H_RES, V_RES, DC_PIN (0: D/C from argument table,
//             1: D/C from i_spi_dc)
//  Macro    : LCD_MADCTL_ORIENT_EN - apply MADCTL MV/MX/MY to coordinates
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_cmd_decoder
   import lcd_cmd_pkg::*;
#(
   parameter int COORD_W = 9,
   parameter int H_RES   = 320,
   parameter int V_RES   = 240,
   parameter int DC_PIN  = 0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   lcd_cmd_decoder_if.slave bus,
   output logic             o_sram_clr_req,
   output logic             o_disp_on,
   output logic             o_inv_on
);
   state_t               state_q, state_d;
   logic [ROM_LEN_W-1:0] cnt_q;
   logic [7:0]           op_q;
   logic [23:0]          shift_q;
   logic [1:0]           pix_cnt_q;
   logic [7:0]           pix_b0_q, pix_b1_q;
   logic [2:0]           colmod_q;
   logic [7:0]           madctl_q;
   logic                 disp_on_q, inv_on_q, clr_q;
   logic                 pix_valid_q;
   logic [17:0]          pix_data_q;
   logic [COORD_W-1:0]   pix_x_q, pix_y_q;

   rom_entry_t           w_rom;
   logic                 w_byte, w_is_cmd, w_is_data, w_pix_last;
   logic                 w_arg_last, w_pix_done, w_cur_load;
   logic                 w_set_col, w_set_row, w_win_rst;
   logic [31:0]          w_arg32;
   logic [15:0]          w_p565;
   logic [17:0]          w_pix_data;
   logic [COORD_W-1:0]   w_cur_x, w_cur_y, w_out_x, w_out_y;
   logic                 w_unused;

   assign w_rom  = arg_rom(bus.i_spi_data);
   // A byte coinciding with CS release is dropped.
   assign w_byte = bus.i_spi_rxdone & ~bus.i_spi_csreleased;

   // With the D/C pin, dc=0 marks a command in any state and dc=1 bytes in
   // IDLE fall through as neither command nor data.
   assign w_is_cmd  = (DC_PIN != 0) ? (w_byte & ~bus.i_spi_dc)
                                    : (w_byte & (state_q == ST_IDLE));
   assign w_is_data = w_byte & ~w_is_cmd & (state_q != ST_IDLE);

   assign w_pix_last = (colmod_q == COLMOD_RGB565) ? (pix_cnt_q == 2'd1)
                                                   : (pix_cnt_q == 2'd2);
   assign w_arg32    = {shift_q, bus.i_spi_data};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      w_arg_last = 1'b0;
      w_pix_done = 1'b0;
      w_cur_load = 1'b0;
      if (bus.i_spi_csreleased) begin
         state_d = ST_IDLE;
      end else if (w_is_cmd) begin
         if (w_rom.varlen) begin
            state_d    = ST_PIXEL;
            w_cur_load = 1'b1;
         end else if (w_rom.exists) begin
            state_d = ST_ARGS;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (w_is_data) begin
         case (state_q)
            ST_ARGS: begin
               if (cnt_q == '0) begin
                  w_arg_last = 1'b1;
                  state_d    = ST_IDLE;
               end
            end
            ST_PIXEL: w_pix_done = w_pix_last;
            default:  state_d = state_q;
         endcase
      end
   end

   assign w_set_col = w_arg_last & (op_q == OP_CASET);
   assign w_set_row = w_arg_last & (op_q == OP_RASET);
   assign w_win_rst = w_is_cmd & (bus.i_spi_data == OP_SWRESET);

   lcd_win_cursor #(
      .COORD_W (COORD_W),
      .H_RES   (H_RES),
      .V_RES   (V_RES)
   ) u_cursor (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_win_rst (w_win_rst),
      .i_set_col (w_set_col),
      .i_set_row (w_set_row),
      .i_start   (w_arg32[16 +: COORD_W]),
      .i_end     (w_arg32[0 +: COORD_W]),
      .i_load    (w_cur_load),
      .i_advance (w_pix_done),
      .o_x       (w_cur_x),
      .o_y       (w_cur_y)
   );

   // RGB565 widens by replicating the MSB of R and B; 18-bit mode keeps the
   // top six bits of each colour byte.
   assign w_p565     = {pix_b0_q, bus.i_spi_data};
   assign w_pix_data = (colmod_q == COLMOD_RGB565)
                     ? {w_p565[15:11], w_p565[15], w_p565[10:5], w_p565[4:0], w_p565[4]}
                     : {pix_b0_q[7:2], pix_b1_q[7:2], bus.i_spi_data[7:2]};

`ifdef LCD_MADCTL_ORIENT_EN
   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);
   logic [COORD_W-1:0] w_sw_x, w_sw_y;

   // Swap first, then mirror each axis.
   assign w_sw_x   = madctl_q[MADCTL_MV] ? w_cur_y : w_cur_x;
   assign w_sw_y   = madctl_q[MADCTL_MV] ? w_cur_x : w_cur_y;
   assign w_out_x  = madctl_q[MADCTL_MX] ? (X_MAX - w_sw_x) : w_sw_x;
   assign w_out_y  = madctl_q[MADCTL_MY] ? (Y_MAX - w_sw_y) : w_sw_y;
   assign w_unused = ^{w_arg32, pix_b1_q[1:0], madctl_q[4:0]};
`else
   // MADCTL is kept as a register but has no effect on the coordinates.
   assign w_out_x  = w_cur_x;
   assign w_out_y  = w_cur_y;
   assign w_unused = ^{w_arg32, pix_b1_q[1:0], madctl_q};
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q       <= '0;
         op_q        <= '0;
         shift_q     <= '0;
         pix_cnt_q   <= '0;
         pix_b0_q    <= '0;
         pix_b1_q    <= '0;
         colmod_q    <= COLMOD_RST;
         madctl_q    <= '0;
         disp_on_q   <= 1'b0;
         inv_on_q    <= 1'b0;
         clr_q       <= 1'b0;
         pix_valid_q <= 1'b0;
         pix_data_q  <= '0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
      end else begin
         clr_q       <= 1'b0;
         pix_valid_q <= 1'b0;
         if (bus.i_spi_csreleased) begin
            pix_cnt_q <= '0;
         end else if (w_is_cmd) begin
            pix_cnt_q <= '0;
            cnt_q     <= w_rom.len_m1;
            op_q      <= bus.i_spi_data;
            case (bus.i_spi_data)
               OP_SWRESET: begin
                  clr_q     <= 1'b1;
                  disp_on_q <= 1'b0;
                  inv_on_q  <= 1'b0;
                  colmod_q  <= COLMOD_RST;
                  madctl_q  <= '0;
               end
               OP_DISPON:  disp_on_q <= 1'b1;
               OP_DISPOFF: disp_on_q <= 1'b0;
               OP_INVON:   inv_on_q  <= 1'b1;
               OP_INVOFF:  inv_on_q  <= 1'b0;
               default:    op_q      <= bus.i_spi_data;
            endcase
         end else if (w_is_data) begin
            if (state_q == ST_ARGS) begin
               shift_q <= w_arg32[23:0];
               cnt_q   <= cnt_q - 1'b1;
               if (w_arg_last) begin
                  case (op_q)
                     OP_COLMOD: colmod_q <= bus.i_spi_data[2:0];
                     OP_MADCTL: madctl_q <= bus.i_spi_data;
                     default:   op_q     <= op_q;
                  endcase
               end
            end else if (w_pix_done) begin
               pix_cnt_q   <= '0;
               pix_valid_q <= 1'b1;
               pix_data_q  <= w_pix_data;
               pix_x_q     <= w_out_x;
               pix_y_q     <= w_out_y;
            end else begin
               pix_cnt_q <= pix_cnt_q + 2'd1;
               if (pix_cnt_q == 2'd0) pix_b0_q <= bus.i_spi_data;
               else                   pix_b1_q <= bus.i_spi_data;
            end
         end
      end
   end

   assign bus.o_pix_valid = pix_valid_q;
   assign bus.o_pix_data  = pix_data_q;
   assign bus.o_pix_x     = pix_x_q;
   assign bus.o_pix_y     = pix_y_q;
   assign o_sram_clr_req  = clr_q;
   assign o_disp_on       = disp_on_q;
   assign o_inv_on        = inv_on_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_cmd_decoder
//  Purpose  : Directed self-checking bench. dut0 infers D/C from the argument
//             table, dut1 takes D/C from the pin. Orientation checks are
//             built when LCD_MADCTL_ORIENT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_cmd_decoder;
   logic clk = 1'b0;
   logic rst_n;
   logic clr0, disp0, inv0, clr1, disp1, inv1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   sel = 0;

   always #5 clk = ~clk;

   lcd_cmd_decoder_if #(.COORD_W(9)) bus0 ();
   lcd_cmd_decoder_if #(.COORD_W(9)) bus1 ();

   lcd_cmd_decoder #(.COORD_W(9), .H_RES(320), .V_RES(240), .DC_PIN(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus0),
      .o_sram_clr_req(clr0), .o_disp_on(disp0), .o_inv_on(inv0)
   );

   lcd_cmd_decoder #(.COORD_W(9), .H_RES(320), .V_RES(240), .DC_PIN(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus1),
      .o_sram_clr_req(clr1), .o_disp_on(disp1), .o_inv_on(inv1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [7:0] b, input logic rx, input logic dc, input logic cs);
      if (sel == 0) begin
         bus0.i_spi_data = b; bus0.i_spi_rxdone = rx;
         bus0.i_spi_dc = dc;  bus0.i_spi_csreleased = cs;
      end else begin
         bus1.i_spi_data = b; bus1.i_spi_rxdone = rx;
         bus1.i_spi_dc = dc;  bus1.i_spi_csreleased = cs;
      end
   endtask

   // One byte strobe; returns #1 after the sampling edge.
   task automatic send(input logic [7:0] b, input logic dc, input logic cs);
      @(negedge clk);
      drive(b, 1'b1, dc, cs);
      @(posedge clk);
      #1;
      drive(8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic cmd(input logic [7:0] b); send(b, 1'b0, 1'b0); endtask
   task automatic dat(input logic [7:0] b); send(b, 1'b1, 1'b0); endtask

   task automatic csrel();
      @(negedge clk);
      drive(8'h00, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      drive(8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic get_out(output logic v, output logic [8:0] x, output logic [8:0] y,
                          output logic [17:0] d, output logic clr, output logic dsp,
                          output logic inv);
      if (sel == 0) begin
         v = bus0.o_pix_valid; x = bus0.o_pix_x; y = bus0.o_pix_y; d = bus0.o_pix_data;
         clr = clr0; dsp = disp0; inv = inv0;
      end else begin
         v = bus1.o_pix_valid; x = bus1.o_pix_x; y = bus1.o_pix_y; d = bus1.o_pix_data;
         clr = clr1; dsp = disp1; inv = inv1;
      end
   endtask

   task automatic expect_pix(input string tag, input logic v, input logic [8:0] x,
                             input logic [8:0] y, input logic [17:0] d);
      logic gv, gc, gd, gi;
      logic [8:0] gx, gy;
      logic [17:0] gdat;
      get_out(gv, gx, gy, gdat, gc, gd, gi);
      check({tag, ".valid"}, 32'(gv), 32'(v));
      if (v) begin
         check({tag, ".x"}, 32'(gx), 32'(x));
         check({tag, ".y"}, 32'(gy), 32'(y));
         check({tag, ".data"}, 32'(gdat), 32'(d));
      end
   endtask

   task automatic expect_ctl(input string tag, input logic clr, input logic dsp, input logic inv);
      logic gv, gc, gd, gi;
      logic [8:0] gx, gy;
      logic [17:0] gdat;
      get_out(gv, gx, gy, gdat, gc, gd, gi);
      check({tag, ".clr"}, 32'(gc), 32'(clr));
      check({tag, ".disp"}, 32'(gd), 32'(dsp));
      check({tag, ".inv"}, 32'(gi), 32'(inv));
   endtask

   task automatic pix2(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [8:0] x, input logic [8:0] y, input logic [17:0] d);
      dat(b0); expect_pix(tag, 1'b0, 9'd0, 9'd0, 18'd0);
      dat(b1); expect_pix(tag, 1'b1, x, y, d);
   endtask

   task automatic pix3(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [8:0] x, input logic [8:0] y,
                       input logic [17:0] d);
      dat(b0); expect_pix(tag, 1'b0, 9'd0, 9'd0, 18'd0);
      dat(b1); expect_pix(tag, 1'b0, 9'd0, 9'd0, 18'd0);
      dat(b2); expect_pix(tag, 1'b1, x, y, d);
   endtask

   initial begin
      rst_n = 1'b0;
      sel = 1; drive(8'h00, 1'b0, 1'b0, 1'b0);
      sel = 0; drive(8'h00, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s;
         expect_pix("reset", 1'b0, 9'd0, 9'd0, 18'd0);
         check("reset.data", 32'(s == 0 ? bus0.o_pix_data : bus1.o_pix_data), 32'd0);
         check("reset.x", 32'(s == 0 ? bus0.o_pix_x : bus1.o_pix_x), 32'd0);
         expect_ctl("reset", 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sel = 0;

      // 18-bit pixels from reset COLMOD, cursor from reset window
      cmd(8'h2C);
      pix3("rgb666_p0", 8'hFC, 8'h00, 8'h00, 9'd0, 9'd0, 18'h3F000);
      pix3("rgb666_p1", 8'h00, 8'h00, 8'hFC, 9'd1, 9'd0, 18'h0003F);
      @(posedge clk); #1;
      expect_pix("rgb666_idle", 1'b0, 9'd0, 9'd0, 18'd0);
      csrel();

      // RGB565 inside a 2x2 window, including the frame wrap
      cmd(8'h3A); dat(8'h05);
      cmd(8'h2A); dat(8'h00); dat(8'h02); dat(8'h00); dat(8'h03);
      cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
      cmd(8'h2C);
      pix2("win_p0", 8'hF8, 8'h00, 9'd2, 9'd5, 18'h3F000);
      pix2("win_p1", 8'hF8, 8'h00, 9'd3, 9'd5, 18'h3F000);
      pix2("win_p2", 8'hF8, 8'h00, 9'd2, 9'd6, 18'h3F000);
      pix2("win_p3", 8'hF8, 8'h00, 9'd3, 9'd6, 18'h3F000);
      pix2("win_wrap", 8'hF8, 8'h00, 9'd2, 9'd5, 18'h3F000);
      csrel();

      // Reversed CASET pair is stored swapped: XS=4, XE=9
      cmd(8'h2A); dat(8'h00); dat(8'h09); dat(8'h00); dat(8'h04);
      cmd(8'h2C);
      for (int i = 0; i < 7; i++)
         pix2("caset_swap", 8'h07, 8'hE0, 9'(i < 6 ? 4 + i : 4), 9'(i < 6 ? 5 : 6), 18'h00FC0);
      csrel();

      // CASET end 0x01FF clamps to 319
      cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h01); dat(8'hFF);
      cmd(8'h2C);
      for (int i = 0; i < 321; i++)
         pix2("caset_clamp", 8'h07, 8'hE0, 9'(i % 320), 9'(5 + i / 320), 18'h00FC0);
      csrel();

      // CS release mid-pixel discards the partial byte
      cmd(8'h3A); dat(8'h06);
      cmd(8'h2C); dat(8'hFC);
      csrel();
      cmd(8'h2C);
      pix3("cs_partial", 8'h00, 8'hFC, 8'h00, 9'd0, 9'd5, 18'h00FC0);
      dat(8'h00); dat(8'h00);
      send(8'hFC, 1'b1, 1'b1);
      expect_pix("cs_coincident_pix", 1'b0, 9'd0, 9'd0, 18'd0);
      send(8'h29, 1'b0, 1'b1);
      expect_ctl("cs_coincident_cmd", 1'b0, 1'b0, 1'b0);

      // Display controls and SWRESET
      cmd(8'h29);
      expect_ctl("dispon", 1'b0, 1'b1, 1'b0);
      cmd(8'h21);
      expect_ctl("invon", 1'b0, 1'b1, 1'b1);
      cmd(8'h01);
      expect_ctl("swreset", 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      expect_ctl("swreset_after", 1'b0, 1'b0, 1'b0);
      cmd(8'h2C);
      pix3("swreset_colmod", 8'h00, 8'h00, 8'hFC, 9'd0, 9'd0, 18'h0003F);
      csrel();

      // D/C pin variant
      sel = 1;
      cmd(8'h2A); dat(8'h00); dat(8'h02); dat(8'h00); dat(8'h03);
      cmd(8'h2A); dat(8'h00); dat(8'h05);
      cmd(8'h2C);
      pix3("dc_abort_caset", 8'hFC, 8'h00, 8'h00, 9'd2, 9'd0, 18'h3F000);
      pix3("dc_next", 8'h00, 8'h00, 8'hFC, 9'd3, 9'd0, 18'h0003F);
      dat(8'hFC);
      cmd(8'h2C);
      pix3("dc_pix_discard", 8'h00, 8'h00, 8'hFC, 9'd2, 9'd0, 18'h0003F);
      cmd(8'h00);
      for (int i = 0; i < 3; i++) begin
         dat(8'hFC);
         expect_pix("dc_idle_data", 1'b0, 9'd0, 9'd0, 18'd0);
      end

`ifdef LCD_MADCTL_ORIENT_EN
      cmd(8'h36); dat(8'h40);
      cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h05);
      cmd(8'h2C);
      pix3("madctl_mx", 8'hFC, 8'h00, 8'h00, 9'd319, 9'd0, 18'h3F000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
